// File: rtl/mult_worker_pkg.sv
// Shared definitions for the shift-add multiplier worker.
package mult_worker_pkg;

    // Handshake state encodings, kept identical to the controller's for waveform consistency.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Iteration counter width for a given operand width (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : mult_worker_pkg

// File: rtl/mult_worker.sv
// Sequential shift-add multiplier, responder side of the start/done handshake.
// One partial product is accumulated per cycle over WIDTH cycles; the result is
// published to product together with a single-cycle done pulse.
module mult_worker
    import mult_worker_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 active,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e            state_q,   state_d;
    logic [WIDTH-1:0]  a_reg_q,   a_reg_d;
    logic [WIDTH-1:0]  b_reg_q,   b_reg_d;
    logic [PW-1:0]     acc_q,     acc_d;
    logic [PW-1:0]     product_q, product_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              active_q,  active_d;
    logic              done_q,    done_d;
    logic [PW-1:0]     addend;

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath: capture in IDLE, one shift-add step per RUN cycle.
    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        addend    = PW'(a_reg_q) << cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_reg_d = a;
                    b_reg_d = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (b_reg_q[cnt_q]) begin
                    acc_d = acc_q + addend;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit processed: publish the completed sum.
                    product_d = acc_d;
                    state_d   = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the upcoming state, so the flops track the state register.
    always_comb begin
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_RUN:  active_d = 1'b1;
            ST_FIN:  done_d   = 1'b1;
            default: begin
                active_d = 1'b0;
                done_d   = 1'b0;
            end
        endcase
    end

    assign active  = active_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : mult_worker

// File: tb/tb_mult_worker.sv
// Self-checking bench for mult_worker: directed and random operations checked
// cycle by cycle against an arithmetic model of the handshake timing.
module tb_mult_worker;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          active;
    logic          done;
    logic [PW-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    // Value product must show: last completed result, or 0 after reset.
    logic [PW-1:0] exp_prod;

    mult_worker #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .active  (active),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from an IDLE cycle: accept, WIDTH RUN cycles, FIN, then the IDLE cycle.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit noisy, input bit stream);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        if (!stream) start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            chk("run_active", {31'b0, active}, 32'd1);
            chk("run_done",   {31'b0, done},   32'd0);
            chk("run_hold",   32'(product),    32'(exp_prod));
            if (noisy) begin
                if (i % 2 == 0) begin
                    a = '1;
                    b = '1;
                end else begin
                    a = W'($urandom);
                    b = W'($urandom);
                end
                start = ~start;
            end
            tick();
        end
        exp_prod = PW'(av) * PW'(bv);
        chk("fin_done",    {31'b0, done},   32'd1);
        chk("fin_active",  {31'b0, active}, 32'd0);
        chk("fin_product", 32'(product),    32'(exp_prod));
        start = stream;
        tick();
        chk("idle_done",    {31'b0, done},   32'd0);
        chk("idle_active",  {31'b0, active}, 32'd0);
        chk("idle_product", 32'(product),    32'(exp_prod));
    endtask

    initial begin
        exp_prod = '0;
        reset_n  = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            tick();
            chk("rst_product", 32'(product),    32'd0);
            chk("rst_done",    {31'b0, done},   32'd0);
            chk("rst_active",  {31'b0, active}, 32'd0);
        end
        start   = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        chk("post_rst_active", {31'b0, active}, 32'd0);
        chk("post_rst_done",   {31'b0, done},   32'd0);

        // Basic multiply and extremes
        do_op(8'd13,  8'd11,  1'b0, 1'b0);
        do_op(8'd255, 8'd255, 1'b0, 1'b0);
        do_op(8'd0,   8'd200, 1'b0, 1'b0);
        do_op(8'd200, 8'd0,   1'b0, 1'b0);
        do_op(8'd1,   8'd128, 1'b0, 1'b0);

        // Streaming with start held through the IDLE gap
        do_op(8'd3, 8'd5, 1'b0, 1'b1);
        do_op(8'd7, 8'd9, 1'b0, 1'b0);

        // Operand isolation with noisy inputs during RUN
        do_op(8'd6, 8'd7, 1'b1, 1'b0);

        // Random operations, some noisy, some streamed
        for (int n = 0; n < 20; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        start = 1'b0;
        tick();

        // Abort during RUN cycle 4
        a     = 8'd99;
        b     = 8'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_abort_active", {31'b0, active}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        exp_prod = '0;
        chk("abort_product", 32'(product),    32'd0);
        chk("abort_active",  {31'b0, active}, 32'd0);
        chk("abort_done",    {31'b0, done},   32'd0);
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < int'(W) + 3; i++) begin
            tick();
            chk("abort_no_done",   {31'b0, done},   32'd0);
            chk("abort_no_active", {31'b0, active}, 32'd0);
            chk("abort_product0",  32'(product),    32'd0);
        end
        do_op(8'd10, 8'd10, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mult_worker

// File: doc/mult_worker.md
Name: mult_worker

Overview:
Sequential shift-add multiplier that serves as the responder side of the team's start/done handshake. An upstream controller raises start, holds its busy state while this block computes, and returns to ready when done pulses. The block captures two unsigned operands and computes their product over WIDTH iterations. It presents the result together with a single-cycle done pulse.

Parameters:
WIDTH, 8, operand width in bits (legal range 2 to 32); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, unsigned; captured on the accepting edge
b  input  WIDTH  multiplier, unsigned; captured on the accepting edge
active  output  1  high while in RUN; Moore output
done  output  1  one-cycle pulse, high only in state FIN; Moore output
product  output  2*WIDTH  result register; valid from the FIN cycle until the next accepting edge

Behaviour:
- Reset: reset_n low asynchronously forces the following, regardless of clock:
  - state=IDLE, product=0, active=0, done=0;
  - internal a_reg, b_reg and cnt cleared.
- State machine: IDLE, RUN, FIN. Encoding is 2 bits. Unused codes go to IDLE on the next edge with outputs 0.
- IDLE:
  - Edge with start=1: a_reg<=a, b_reg<=b, acc<=0, cnt<=0, go to RUN.
  - start=0: remain in IDLE; product holds its last value.
- RUN, each edge:
  - If b_reg[cnt]=1, acc <= acc + (a_reg << cnt). Use a 2*WIDTH-bit add; no overflow is possible.
  - cnt increments.
  - When cnt = WIDTH-1 on that edge, go to FIN and load the final acc into product.
- cnt width is $clog2(WIDTH); wrap never occurs because the exit happens at WIDTH-1.
- FIN: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in FIN.
- Latency, with start accepted at edge k:
  - RUN occupies the cycles after edges k..k+WIDTH-1.
  - done is high in the cycle after edge k+WIDTH.
  - Total: WIDTH+1 cycles from the accepting edge to done.
- Back-to-back operation: with start held high continuously, the next operation is accepted at the edge after the FIN cycle. That gives one IDLE cycle between done pulses, for a period of WIDTH+2 cycles.
- start, a and b changing during RUN or FIN have no effect; the operands are already captured.
- product changes only at the RUN→FIN transition and on reset. The accepting edge does not clear product; only the internal acc is cleared.
- Reset mid-operation (during RUN or FIN):
  - Immediate abort: outputs go to their reset values.
  - No done pulse is emitted for the aborted operation.
  - The first edge after reset_n deasserts is in IDLE.
- Handshake compatibility: done is never high for more than one consecutive cycle, so the upstream controller sees exactly one completion per start.

Decomposition:
- Shared package/header: the 2-bit state encodings (IDLE=2'b00, RUN=2'b01, FIN=2'b10), shared with the controller's encodings for waveform consistency.
- Shared package/header: a CNT_W helper constant derived from WIDTH.
- No sub-module. Keep three processes: the state/datapath register, next-state logic, and the Moore output decode.

Test Plan:
- Reset: hold reset_n=0 with random inputs → product=0, done=0, active=0. Pull reset_n low asynchronously between edges → outputs clear before the next edge.
- Basic multiply: WIDTH=8, a=13, b=11, pulse start for 1 cycle → active high for 8 cycles, done high for exactly 1 cycle 9 cycles after the accepting edge, product=143.
- Extremes:
  - a=255, b=255 → product=65025.
  - a=0, b=200 → 0.
  - a=200, b=0 → 0.
  - a=1, b=128 → 128.
  - Each case has identical latency.
- Streaming: start held high, operand pairs (3,5), (7,9) → done pulses 10 cycles apart with product=15 then 63. No double pulse; one IDLE cycle between operations.
- Operand isolation: capture a=6, b=7, then drive a=b=255 and toggle start during RUN → product=42, exactly one done pulse.
- Abort: assert reset_n=0 at RUN cycle 4 → no done pulse, product=0. Next start with (10,10) → product=100 after normal latency.
